// File: rtl/interfaz_teclado_hex_if.sv
// -----------------------------------------------------------------------------
// interfaz_teclado_hex_if
// Purpose : bundles the keypad-side and digit-side signals of the hex keypad
//           interface so they travel as one port.
// Signals : row_in    [3:0]  keypad rows, active-low, asynchronous to clk
//           col_out   [3:0]  keypad column drive, active-low, one-hot low
//           key_code  [3:0]  code of the last accepted key
//           key_valid        one-cycle pulse per accepted key
//           data_out  [15:0] last four accepted digits, newest in [3:0]
// Modports: slave  - the keypad interface block itself
//           master - the environment (keypad matrix and display side)
// -----------------------------------------------------------------------------
interface interfaz_teclado_hex_if;
   logic [3:0]  row_in;
   logic [3:0]  col_out;
   logic [3:0]  key_code;
   logic        key_valid;
   logic [15:0] data_out;

   modport slave  (input  row_in,
                   output col_out, key_code, key_valid, data_out);

   modport master (output row_in,
                   input  col_out, key_code, key_valid, data_out);
endinterface

// File: rtl/interfaz_teclado_hex.sv
// -----------------------------------------------------------------------------
// interfaz_teclado_hex
// Purpose : scans a 4x4 hex matrix keypad one column at a time, synchronizes
//           and debounces the rows, encodes each accepted press as
//           {row_idx, col_idx} and shifts it into a 16-bit digit register that
//           feeds the 7-segment display path directly.
// Ports   : clk  - system clock
//           rst  - asynchronous, active-high reset
//           kp   - interfaz_teclado_hex_if.slave
//                  (row_in, col_out, key_code, key_valid, data_out)
// Options : define KEY_REPEAT_EN to emit a repeat pulse every REPEAT_CYCLES
//           cycles while a key stays held; undefined gives one pulse per press.
// -----------------------------------------------------------------------------
module interfaz_teclado_hex #(
   parameter int SCAN_DIV        = 100_000,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int REPEAT_CYCLES   = 25_000_000
) (
   input  logic                   clk,
   input  logic                   rst,
   interfaz_teclado_hex_if.slave  kp
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int DEB_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2,
      RELEASE  = 2'd3
   } state_t;

   // Lowest-index low row wins when several rows are pressed.
   function automatic logic [1:0] first_low_row(input logic [3:0] rows);
      logic [1:0] idx;
      if (!rows[0])      idx = 2'd0;
      else if (!rows[1]) idx = 2'd1;
      else if (!rows[2]) idx = 2'd2;
      else               idx = 2'd3;
      return idx;
   endfunction

   // Active-low one-hot column drive for a column index.
   function automatic logic [3:0] col_drive(input logic [1:0] idx);
      return ~(4'b0001 << idx);
   endfunction

   logic [3:0]       sync1_q, rows_s_q;
   state_t           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [DEB_W-1:0] deb_q, deb_d;
   logic [1:0]       col_idx_q, col_idx_d;
   logic [1:0]       row_idx_q, row_idx_d;
   logic [3:0]       col_out_q, col_out_d;
   logic [3:0]       key_code_q, key_code_d;
   logic             key_valid_q, key_valid_d;
   logic [15:0]      data_q, data_d;
   logic             row_low_s;

`ifdef KEY_REPEAT_EN
   localparam int REP_W = ($clog2(REPEAT_CYCLES) > 0) ? $clog2(REPEAT_CYCLES) : 1;
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
   logic [REP_W-1:0] rep_q, rep_d;
`endif

   // Only the latched row is watched once a candidate key has been found.
   assign row_low_s = ~rows_s_q[row_idx_q];

   // Two-flop row synchronizer plus all state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q     <= 4'b0000;
         rows_s_q    <= 4'b0000;
         state_q     <= SCAN;
         div_q       <= '0;
         deb_q       <= '0;
         col_idx_q   <= 2'd0;
         row_idx_q   <= 2'd0;
         col_out_q   <= 4'b1110;
         key_code_q  <= 4'h0;
         key_valid_q <= 1'b0;
         data_q      <= 16'h0000;
`ifdef KEY_REPEAT_EN
         rep_q       <= '0;
`endif
      end else begin
         sync1_q     <= kp.row_in;
         rows_s_q    <= sync1_q;
         state_q     <= state_d;
         div_q       <= div_d;
         deb_q       <= deb_d;
         col_idx_q   <= col_idx_d;
         row_idx_q   <= row_idx_d;
         col_out_q   <= col_out_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         data_q      <= data_d;
`ifdef KEY_REPEAT_EN
         rep_q       <= rep_d;
`endif
      end
   end

   // Scan / debounce / hold / release next-state and output logic.
   always_comb begin
      state_d     = state_q;
      div_d       = div_q;
      deb_d       = deb_q;
      col_idx_d   = col_idx_q;
      row_idx_d   = row_idx_q;
      col_out_d   = col_out_q;
      key_code_d  = key_code_q;
      key_valid_d = 1'b0;
      data_d      = data_q;
`ifdef KEY_REPEAT_EN
      rep_d       = '0;
`endif

      case (state_q)
         SCAN: begin
            if (div_q == DIV_LAST) begin
               div_d = '0;
               if (rows_s_q != 4'hF) begin
                  // Column stays where it is so the pressed key remains driven.
                  row_idx_d = first_low_row(rows_s_q);
                  deb_d     = '0;
                  state_d   = DEBOUNCE;
               end else begin
                  col_idx_d = col_idx_q + 2'd1;
                  col_out_d = col_drive(col_idx_q + 2'd1);
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end

         DEBOUNCE: begin
            if (row_low_s) begin
               if (deb_q == DEB_LAST) begin
                  state_d     = HELD;
                  deb_d       = '0;
                  key_valid_d = 1'b1;
                  key_code_d  = {row_idx_q, col_idx_q};
                  data_d      = {data_q[11:0], row_idx_q, col_idx_q};
               end else begin
                  deb_d = deb_q + DEB_W'(1);
               end
            end else begin
               // Bounce: resample the same column from a fresh scan period.
               state_d = SCAN;
               div_d   = '0;
            end
         end

         HELD: begin
            if (!row_low_s) begin
               deb_d   = '0;
               state_d = RELEASE;
            end else begin
`ifdef KEY_REPEAT_EN
               if (rep_q == REP_LAST) begin
                  rep_d       = '0;
                  key_valid_d = 1'b1;
                  data_d      = {data_q[11:0], key_code_q};
               end else begin
                  rep_d = rep_q + REP_W'(1);
               end
`else
               state_d = HELD;
`endif
            end
         end

         RELEASE: begin
            if (row_low_s) begin
               // Release bounce: back to HELD, no new pulse.
               state_d = HELD;
            end else if (deb_q == DEB_LAST) begin
               state_d   = SCAN;
               div_d     = '0;
               deb_d     = '0;
               col_idx_d = col_idx_q + 2'd1;
               col_out_d = col_drive(col_idx_q + 2'd1);
            end else begin
               deb_d = deb_q + DEB_W'(1);
            end
         end

         default: begin
            state_d = SCAN;
            div_d   = '0;
         end
      endcase
   end

   assign kp.col_out   = col_out_q;
   assign kp.key_code  = key_code_q;
   assign kp.key_valid = key_valid_q;
   assign kp.data_out  = data_q;

endmodule
